// File: rtl/riscv_pkg.sv
// Shared opcode constants, NOP encoding and fetch FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

    // Base opcodes seen by the decoder, plus the local HALT extension
    localparam logic [6:0] OPC_HALT  = 7'b0000001;
    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    function automatic logic is_halt(input logic [6:0] opc);
        return opc == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with clear (flush/bubble), load (capture) and hold.
// Latency: 1 cycle from load to outputs.
// Backpressure: hold whenever neither load nor clear is asserted (stall).
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            id_valid,
    output logic [PC_W-1:0] id_pc,
    output logic [31:0]     id_instr
);

    // Clear wins over load; id_pc is kept on clear so only the instruction is killed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_instr <= INSTR_NOP;
        end else if (clear) begin
            id_valid <= 1'b0;
            id_instr <= INSTR_NOP;
        end else if (load) begin
            id_valid <= 1'b1;
            id_pc    <= in_pc;
            id_instr <= in_instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, next-PC mux, FETCH/HALTED FSM and IF/ID; optional IF_PERF_CNT_EN counters.
// Latency: 1 cycle imem_ready -> id_valid; 1 instr/cycle with zero wait states.
// Backpressure: stall holds PC and IF/ID; imem_ready low inserts bubbles; flush overrides both.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    input  logic            stall,
    input  logic            flush,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            id_valid,
    output logic [PC_W-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode,
    output logic            halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_bubbles
`endif
);

    localparam logic [PC_W-1:0] ALIGN_MASK    = ~PC_W'(3);
    localparam logic [PC_W-1:0] RESET_PC_ALGN = RESET_PC & ALIGN_MASK;

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] redirect_algn;
    logic            in_fetch;
    logic            ifid_load;
    logic            ifid_clear;

    assign redirect_algn = redirect_pc & ALIGN_MASK;
    assign in_fetch      = (state == FETCH);

    // A capture happens only in FETCH when nothing higher-priority claims the cycle
    always_comb begin
        ifid_load  = in_fetch && !flush && !stall && imem_ready;
        ifid_clear = flush || (!stall && !ifid_load);
    end

    // Request is gated by reset so nothing is issued while reset is asserted
    assign imem_req  = reset && in_fetch;
    assign imem_addr = pc;

    // FSM, PC register and halted flag; flush is the only way out of HALTED
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FETCH;
            pc     <= RESET_PC_ALGN;
            halted <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (flush) begin
                        pc <= redirect_algn;
                    end else if (!stall && imem_ready) begin
                        pc <= pc + PC_W'(4);
                        if (is_halt(imem_rdata[6:0])) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (flush) begin
                        pc     <= redirect_algn;
                        state  <= FETCH;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= FETCH;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg #(
        .PC_W (PC_W)
    ) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .load     (ifid_load),
        .clear    (ifid_clear),
        .in_pc    (pc),
        .in_instr (imem_rdata),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_instr (id_instr)
    );

    assign id_opcode = id_instr[6:0];

`ifdef IF_PERF_CNT_EN
    logic bubble_evt;

    // A FETCH cycle leaves IF/ID empty unless it captures or a stall keeps a live instruction
    assign bubble_evt = in_fetch && !flush && !ifid_load && !(stall && id_valid);

    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (ifid_load && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (bubble_evt && (perf_bubbles != 32'hFFFF_FFFF)) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus random bench for fetch_stage against a cycle-level reference model.
// Two instances share stimulus: default RESET_PC and RESET_PC=32'hFFFF_FFFC.
// Outputs are sampled on the falling edge, inputs driven just after it.
module tb_fetch_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RPC_B = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        req_a, vld_a, halt_a, req_b, vld_b, halt_b;
    logic [31:0] addr_a, ipc_a, ins_a, addr_b, ipc_b, ins_b;
    logic [6:0]  opc_a, opc_b;
`ifdef IF_PERF_CNT_EN
    logic [31:0] pf_a, pb_a, pf_b, pb_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_stage #(.PC_W(32), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .reset(reset), .imem_req(req_a), .imem_addr(addr_a),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
        .flush(flush), .redirect_pc(redirect_pc), .id_valid(vld_a),
        .id_pc(ipc_a), .id_instr(ins_a), .id_opcode(opc_a), .halted(halt_a)
`ifdef IF_PERF_CNT_EN
        , .perf_fetched(pf_a), .perf_bubbles(pb_a)
`endif
    );

    fetch_stage #(.PC_W(32), .RESET_PC(RPC_B)) dut_b (
        .clk(clk), .reset(reset), .imem_req(req_b), .imem_addr(addr_b),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
        .flush(flush), .redirect_pc(redirect_pc), .id_valid(vld_b),
        .id_pc(ipc_b), .id_instr(ins_b), .id_opcode(opc_b), .halted(halt_b)
`ifdef IF_PERF_CNT_EN
        , .perf_fetched(pf_b), .perf_bubbles(pb_b)
`endif
    );

    // Architectural view of the stage: where fetch is, whether it stopped, what ID holds
    typedef struct {
        bit          stopped;
        logic [31:0] pc;
        bit          vld;
        logic [31:0] ipc;
        logic [31:0] instr;
        longint      fetched;
        longint      bubbles;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset(input logic [31:0] rpc);
        mdl_t m;
        m.stopped = 0; m.pc = rpc; m.vld = 0; m.ipc = '0; m.instr = NOP;
        m.fetched = 0; m.bubbles = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input bit rdy, input logic [31:0] rd,
                                      input bit st, input bit fl, input logic [31:0] rp);
        mdl_t n = m;
        if (fl) begin
            n.pc = {rp[31:2], 2'b00};
            n.stopped = 0; n.vld = 0; n.instr = NOP;
        end else if (st) begin
            if (!m.stopped && !m.vld) n.bubbles++;
        end else if (!m.stopped && rdy) begin
            n.vld = 1; n.ipc = m.pc; n.instr = rd;
            n.pc = (m.pc + 32'd4) % 33'h1_0000_0000;
            n.fetched++;
            if (rd[6:0] == 7'h01) n.stopped = 1;
        end else begin
            n.vld = 0; n.instr = NOP;
            if (!m.stopped) n.bubbles++;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmp_dut(input string nm, input mdl_t m, input logic req,
                           input logic [31:0] addr, input logic v, input logic [31:0] ipc,
                           input logic [31:0] ins, input logic [6:0] opc, input logic h);
        chk({nm, ".imem_req"},  {31'b0, req}, {31'b0, reset && !m.stopped});
        chk({nm, ".imem_addr"}, addr, m.pc);
        chk({nm, ".id_valid"},  {31'b0, v}, {31'b0, m.vld});
        chk({nm, ".id_pc"},     ipc, m.ipc);
        chk({nm, ".id_instr"},  ins, m.instr);
        chk({nm, ".id_opcode"}, {25'b0, opc}, {25'b0, m.instr[6:0]});
        chk({nm, ".halted"},    {31'b0, h}, {31'b0, m.stopped});
    endtask

    task automatic check_all();
        cmp_dut("a", ma, req_a, addr_a, vld_a, ipc_a, ins_a, opc_a, halt_a);
        cmp_dut("b", mb, req_b, addr_b, vld_b, ipc_b, ins_b, opc_b, halt_b);
`ifdef IF_PERF_CNT_EN
        chk("a.perf_fetched", pf_a, 32'(ma.fetched));
        chk("a.perf_bubbles", pb_a, 32'(ma.bubbles));
        chk("b.perf_fetched", pf_b, 32'(mb.fetched));
        chk("b.perf_bubbles", pb_b, 32'(mb.bubbles));
`endif
    endtask

    // One clock: drive inputs after the falling edge, advance models, check at next falling edge
    task automatic cyc(input bit rdy, input logic [31:0] rd, input bit st,
                       input bit fl, input logic [31:0] rp);
        imem_ready = rdy; imem_rdata = rd; stall = st; flush = fl; redirect_pc = rp;
        if (reset) begin
            ma = mdl_step(ma, rdy, rd, st, fl, rp);
            mb = mdl_step(mb, rdy, rd, st, fl, rp);
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic rnd_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bit          rdy, st, fl;
            logic [31:0] rd, rp;
            rdy = ($urandom % 4) != 0;
            st  = ($urandom % 6) == 0;
            fl  = ($urandom % 10) == 0;
            rp  = $urandom;
            rd  = $urandom;
            if (($urandom % 8) == 0) rd[6:0] = 7'h01;
            cyc(rdy, rd, st, fl, rp);
        end
    endtask

    initial begin
        ma = mdl_reset(32'h0);
        mb = mdl_reset(RPC_B);

        // Reset state
        repeat (3) @(negedge clk);
        check_all();
        reset = 1'b1;
        #1;
        check_all();
        chk("b.reset_addr", addr_b, 32'hFFFF_FFFC);

        // Zero-wait-state fetch; instance b wraps from 0xFFFF_FFFC to 0
        cyc(1'b1, 32'h0050_0093, 1'b0, 1'b0, '0);
        chk("b.wrap_addr", addr_b, 32'h0000_0000);
        chk("a.first_pc", ipc_a, 32'h0);
        cyc(1'b1, 32'h00a0_0113, 1'b0, 1'b0, '0);
        chk("a.addr_after2", addr_a, 32'h8);

        // Two memory wait states at 0x8, then capture
        cyc(1'b0, $urandom, 1'b0, 1'b0, '0);
        cyc(1'b0, $urandom, 1'b0, 1'b0, '0);
        cyc(1'b1, 32'h0000_0513, 1'b0, 1'b0, '0);
        chk("a.capture_after_wait", ipc_a, 32'h8);

        // Stall with ready high: nothing moves
        for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b1, 1'b0, '0);

        // Flush wins over stall; target gets word-aligned
        cyc(1'b1, $urandom, 1'b1, 1'b1, 32'h0000_0103);
        chk("a.flush_addr", addr_a, 32'h100);

        // HALT at 0x20, idle and stall in HALTED, then flush out to 0x40
        cyc(1'b0, $urandom, 1'b0, 1'b1, 32'h20);
        cyc(1'b1, 32'h0000_0001, 1'b0, 1'b0, '0);
        chk("a.halt_opcode", {25'b0, opc_a}, 32'h01);
        cyc(1'b1, $urandom, 1'b0, 1'b0, '0);
        cyc(1'b1, $urandom, 1'b1, 1'b0, '0);
        cyc(1'b1, $urandom, 1'b0, 1'b0, '0);
        cyc(1'b0, $urandom, 1'b0, 1'b1, 32'h40);
        chk("a.resume_addr", addr_a, 32'h40);
        cyc(1'b1, 32'h0000_0093, 1'b0, 1'b0, '0);

        // Random traffic
        rnd_cycles(600);

        // Asynchronous reset mid-stream, away from any clock edge
        @(posedge clk);
        #2;
        reset = 1'b0;
        ma = mdl_reset(32'h0);
        mb = mdl_reset(RPC_B);
        #1;
        chk("a.arst_vld", {31'b0, vld_a}, 32'h0);
        chk("b.arst_vld", {31'b0, vld_b}, 32'h0);
        chk("b.arst_addr", addr_b, 32'hFFFF_FFFC);
        @(negedge clk);
        check_all();
        reset = 1'b1;
        rnd_cycles(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
